// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage -- memory stage between the execute ALU and writeback.
//
// Holds one instruction at a time. Loads and stores do a request/grant/response
// exchange with the data memory: store data is replicated across byte lanes
// with a matching byte mask, and load data is sign- or zero-extended from the
// addressed lane. Any other instruction passes the ALU result to writeback.
// Misaligned accesses (when ALIGN_CHECK=1) and illegal funct3 values skip the
// bus and report exc along with the writeback.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid / in_ready         execute-side handshake (in_ready only in IDLE)
//   in_addr, in_wdata, in_inst  ALU result, rs2 value, instruction word
//   mem_req / mem_gnt           bus request, accepted when mem_gnt is high
//   mem_we, mem_addr            store flag, word-aligned address
//   mem_wmask, mem_wdata        byte enables, lane-replicated store data
//   mem_rvalid, mem_rdata       load response
//   wb_valid / wb_ready         writeback handshake
//   wb_we, wb_rd, wb_data       register write enable, destination, value
//   exc                         misaligned or illegal access (with wb_valid)
// -----------------------------------------------------------------------------
module lsu_stage #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_inst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t state_q, state_d;

  // Attributes of the captured instruction needed after IDLE.
  logic       is_store_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction (only meaningful in IDLE with in_valid)
  // ---------------------------------------------------------------------------
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [1:0]  off;
  logic        is_load, is_store, is_mem;
  logic        illegal, misaligned, exc_in;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic        unused_inst;

  assign op       = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign f3       = in_inst[14:12];
  assign off      = in_addr[1:0];
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_mem   = is_load | is_store;

  // Immediate/funct7 bits are irrelevant to this stage.
  assign unused_inst = ^in_inst[31:15];

  // Stores: funct3 3..7 illegal. Loads: 3, 6 and 7 illegal.
  assign illegal = is_store ? (f3[2] | (f3[1:0] == 2'b11))
                 : is_load  ? ((f3[1:0] == 2'b11) | (f3[2] & f3[1]))
                 : 1'b0;

  assign misaligned = ALIGN_CHECK && is_mem &&
                      (((f3[1:0] == 2'b01) && off[0]) ||
                       ((f3[1:0] == 2'b10) && (off != 2'b00)));

  assign exc_in = illegal | misaligned;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and a latch is never inferred.
    st_mask = 4'b1111;
    st_data = in_wdata;
    case (f3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << off;
        st_data = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-data formatting from the captured funct3 and byte offset
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (off_q)
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      2'b11:   lane_b = mem_rdata[31:24];
      default: ;
    endcase
  end

  assign lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_data = {24'h0, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_data = {16'h0, lane_h};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs follow the state directly, so an asynchronous reset
  // drops mem_req and wb_valid at once.
  // ---------------------------------------------------------------------------
  assign in_ready = (state_q == IDLE);
  assign mem_req  = (state_q == REQ);
  assign wb_valid = (state_q == OUT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (is_mem && !exc_in) ? REQ : OUT;
      REQ: begin
        if (mem_gnt) begin
          // A response arriving with the grant completes the load directly.
          if (is_store_q || mem_rvalid) state_d = OUT;
          else                          state_d = RESP;
        end
      end
      RESP:    if (mem_rvalid) state_d = OUT;
      OUT:     if (wb_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: datapath registers are reset too because their reset values are
    // visible on the bus and writeback ports.
    if (!resetn) begin
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wmask  <= 4'h0;
      mem_wdata  <= 32'h0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0;
      exc        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            is_store_q <= is_store;
            f3_q       <= f3;
            off_q      <= off;
            wb_rd      <= rd;
            wb_we      <= 1'b0;
            wb_data    <= 32'h0;
            exc        <= 1'b0;
            if (is_mem && !exc_in) begin
              mem_we    <= is_store;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_wmask <= is_store ? st_mask : 4'h0;
              mem_wdata <= is_store ? st_data : 32'h0;
            end else if (exc_in) begin
              exc <= 1'b1;
            end else begin
              wb_data <= in_addr;
              wb_we   <= (rd != 5'd0);
            end
          end
        end
        REQ: begin
          if (mem_gnt && mem_rvalid && !is_store_q) begin
            wb_data <= ld_data;
            wb_we   <= (wb_rd != 5'd0);
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            wb_data <= ld_data;
            wb_we   <= (wb_rd != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_stage -- self-checking bench for lsu_stage.
//
// A transaction-level reference model computes, for each instruction, the bus
// request it must produce (if any) and the writeback it must deliver. The
// driver plays both the execute stage and the data memory with randomized
// delays; a single compare process checks the DUT outputs every cycle against
// what the model and the handshakes seen so far demand.
// -----------------------------------------------------------------------------
module tb_lsu_stage;

  localparam bit ALIGN = 1'b1;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ALU   = 7'h33;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;

  lsu_stage #(.ALIGN_CHECK(ALIGN)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_inst    (in_inst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .exc        (exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: what one instruction must do, from the instruction rules
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        mem;     // a bus request must be issued
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  wmask;
    logic [31:0] mwdata;
    logic        wb_we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t        e;
    int          f3, off;
    bit          ld, st, bad;
    logic [31:0] b, h;
    e   = '0;
    e.rd = inst[11:7];
    f3  = int'(inst[14:12]);
    off = int'(addr[1:0]);
    ld  = (inst[6:0] == OP_LOAD);
    st  = (inst[6:0] == OP_STORE);
    if (!ld && !st) begin
      e.wb_we = (e.rd != 0);
      e.data  = addr;
      return e;
    end
    bad = st ? (f3 > 2) : (f3 == 3 || f3 > 5);
    if (ALIGN && (((f3 % 4) == 1 && (off % 2) == 1) || ((f3 % 4) == 2 && off != 0)))
      bad = 1'b1;
    if (bad) begin
      e.exc = 1'b1;
      return e;
    end
    e.mem   = 1'b1;
    e.we    = st;
    e.maddr = addr & ~32'h3;
    if (st) begin
      case (f3)
        0: begin
          e.wmask  = 4'b0001 << off;
          e.mwdata = {24'h0, wdata[7:0]} * 32'h0101_0101;
        end
        1: begin
          e.wmask  = (off >= 2) ? 4'hC : 4'h3;
          e.mwdata = {16'h0, wdata[15:0]} * 32'h0001_0001;
        end
        default: begin
          e.wmask  = 4'hF;
          e.mwdata = wdata;
        end
      endcase
    end else begin
      b = (rdata >> (8 * off)) & 32'hFF;
      h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
        0:       e.data = (b >= 128)   ? b + 32'hFFFF_FF00 : b;
        4:       e.data = b;
        1:       e.data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        5:       e.data = h;
        default: e.data = rdata;
      endcase
      e.wb_we = (e.rd != 0);
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard state shared between the driver and the compare process
  // ---------------------------------------------------------------------------
  exp_t exp_cur;
  bit   busy;      // an instruction was accepted and not yet handed to writeback
  bit   granted;   // its bus request has been granted
  bit   returned;  // its load data has been delivered
  bit   pinned;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic coin();
    return 1'($urandom & 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: outputs sampled on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : compare
    exp_t m;
    logic want_req, done;
    if (!pinned) begin
      pinned = 1'b1;
      m = model(mk(OP_ALU, 3'd0, 5'd5), 32'h2A, 32'h0, 32'h0);
      check("pin_add_data", m.data, 32'h2A);
      check("pin_add_we", {31'h0, m.wb_we}, 32'h1);
      m = model(mk(OP_STORE, 3'd0, 5'd0), 32'h1003, 32'hA5, 32'h0);
      check("pin_sb_addr", m.maddr, 32'h1000);
      check("pin_sb_mask", {28'h0, m.wmask}, 32'h8);
      check("pin_sb_wdata", m.mwdata, 32'hA5A5_A5A5);
      m = model(mk(OP_LOAD, 3'd0, 5'd3), 32'h2002, 32'h0, 32'h0080_0000);
      check("pin_lb_data", m.data, 32'hFFFF_FF80);
      m = model(mk(OP_LOAD, 3'd4, 5'd3), 32'h2002, 32'h0, 32'h0080_0000);
      check("pin_lbu_data", m.data, 32'h0000_0080);
      m = model(mk(OP_LOAD, 3'd2, 5'd3), 32'h2001, 32'h0, 32'h0);
      check("pin_lw_mis_exc", {31'h0, m.exc}, 32'h1);
      check("pin_lw_mis_mem", {31'h0, m.mem}, 32'h0);
    end
    if (!resetn) begin
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      check("rst_wb_we", {31'h0, wb_we}, 32'h0);
      check("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_exc", {31'h0, exc}, 32'h0);
    end else begin
      want_req = busy && exp_cur.mem && !granted;
      done     = busy && (!exp_cur.mem || (granted && (exp_cur.we || returned)));
      check("in_ready", {31'h0, in_ready}, {31'h0, !busy});
      check("mem_req", {31'h0, mem_req}, {31'h0, want_req});
      if (want_req && mem_req) begin
        check("mem_we", {31'h0, mem_we}, {31'h0, exp_cur.we});
        check("mem_addr", mem_addr, exp_cur.maddr);
        if (exp_cur.we) begin
          check("mem_wmask", {28'h0, mem_wmask}, {28'h0, exp_cur.wmask});
          check("mem_wdata", mem_wdata, exp_cur.mwdata);
        end
      end
      check("wb_valid", {31'h0, wb_valid}, {31'h0, done});
      if (done && wb_valid) begin
        check("exc", {31'h0, exc}, {31'h0, exp_cur.exc});
        check("wb_we", {31'h0, wb_we}, {31'h0, exp_cur.wb_we});
        if (exp_cur.wb_we) check("wb_rd", {27'h0, wb_rd}, {27'h0, exp_cur.rd});
        if (exp_cur.wb_we || exp_cur.exc) check("wb_data", wb_data, exp_cur.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one instruction through the stage. Entered and left at posedge+1.
  // gd = cycles before grant, rdl = cycles from grant to load data (0 = same
  // cycle), wd = cycles wb_ready is held low.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gd, input int rdl, input int wd);
    exp_cur  = model(inst, addr, wdata, rdata);
    granted  = 1'b0;
    returned = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_addr  = addr;
    in_wdata = wdata;
    wb_ready = coin();
    @(posedge clk); #1;
    busy     = 1'b1;
    in_valid = 1'b0;
    in_inst  = $urandom;
    in_addr  = $urandom;
    in_wdata = $urandom;
    if (exp_cur.mem) begin
      for (int i = 0; i < gd; i++) begin
        mem_rvalid = coin();
        mem_rdata  = $urandom;
        wb_ready   = coin();
        @(posedge clk); #1;
      end
      mem_gnt    = 1'b1;
      mem_rvalid = !exp_cur.we && (rdl == 0);
      mem_rdata  = rdata;
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      granted    = 1'b1;
      if (!exp_cur.we) begin
        if (rdl == 0) begin
          returned = 1'b1;
        end else begin
          for (int i = 1; i < rdl; i++) begin
            mem_rdata = $urandom;
            @(posedge clk); #1;
          end
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          returned   = 1'b1;
        end
      end
    end
    for (int i = 0; i < wd; i++) begin
      wb_ready   = 1'b0;
      mem_rvalid = coin();
      mem_rdata  = $urandom;
      @(posedge clk); #1;
    end
    wb_ready   = 1'b1;
    mem_rvalid = coin();
    @(posedge clk); #1;
    wb_ready   = 1'b0;
    mem_rvalid = 1'b0;
    busy       = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    busy        = 1'b0;
    granted     = 1'b0;
    returned    = 1'b0;
    exp_cur     = '0;
    in_valid    = 1'b0;
    in_addr     = 32'h0;
    in_wdata    = 32'h0;
    in_inst     = 32'h0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    wb_ready    = 1'b0;
    resetn      = 1'b1;
    #1 resetn   = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn   = 1'b1;

    // Directed cases
    run_op(mk(OP_ALU, 3'd0, 5'd5), 32'h0000_002A, 32'h0, 32'h0, 0, 0, 0);
    run_op(mk(OP_STORE, 3'd0, 5'd0), 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, 0, 0);
    run_op(mk(OP_LOAD, 3'd0, 5'd3), 32'h0000_2002, 32'h0, 32'h0080_0000, 1, 3, 0);
    run_op(mk(OP_LOAD, 3'd4, 5'd3), 32'h0000_2002, 32'h0, 32'h0080_0000, 1, 3, 0);
    run_op(mk(OP_LOAD, 3'd0, 5'd3), 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 0, 0);
    run_op(mk(OP_LOAD, 3'd2, 5'd4), 32'h0000_2001, 32'h0, 32'h0, 0, 0, 1);
    run_op(mk(OP_LOAD, 3'd3, 5'd4), 32'h0000_2000, 32'h0, 32'h0, 0, 0, 0);
    run_op(mk(OP_LOAD, 3'd2, 5'd0), 32'h0000_2004, 32'h0, 32'h1234_5678, 0, 1, 4);
    run_op(mk(OP_STORE, 3'd1, 5'd0), 32'h0000_3002, 32'hDEAD_BEEF, 32'h0, 1, 0, 2);
    run_op(mk(OP_LOAD, 3'd5, 5'd9), 32'h0000_3002, 32'h0, 32'h8765_4321, 0, 2, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [6:0]  op;
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    op = OP_LOAD;
        2, 3:    op = OP_STORE;
        4:       op = OP_ALU;
        default: op = 7'($urandom);
      endcase
      a = $urandom;
      if (coin()) a[1:0] = 2'b00;
      run_op(mk(op, 3'($urandom), 5'($urandom)), a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
    end

    // Reset while the request is outstanding
    exp_cur  = model(mk(OP_LOAD, 3'd2, 5'd7), 32'h0000_3000, 32'h0, 32'h0);
    granted  = 1'b0;
    returned = 1'b0;
    in_valid = 1'b1;
    in_inst  = mk(OP_LOAD, 3'd2, 5'd7);
    in_addr  = 32'h0000_3000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    @(posedge clk); #1;
    resetn   = 1'b0;
    busy     = 1'b0;
    @(posedge clk); #1;
    resetn   = 1'b1;
    @(posedge clk); #1;

    // Reset while waiting for load data; a late response must be ignored and
    // inputs presented during reset must not be captured.
    exp_cur  = model(mk(OP_LOAD, 3'd2, 5'd7), 32'h0000_3004, 32'h0, 32'h0);
    granted  = 1'b0;
    returned = 1'b0;
    in_valid = 1'b1;
    in_inst  = mk(OP_LOAD, 3'd2, 5'd7);
    in_addr  = 32'h0000_3004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    mem_gnt  = 1'b1;
    @(posedge clk); #1;
    mem_gnt  = 1'b0;
    granted  = 1'b1;
    @(posedge clk); #1;
    resetn   = 1'b0;
    busy     = 1'b0;
    in_valid = 1'b1;
    in_inst  = mk(OP_ALU, 3'd0, 5'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_op(mk(OP_LOAD, 3'd2, 5'd8), 32'h0000_4000, 32'h0, 32'h1357_9BDF, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result (effective address or arithmetic result), rs2 data and the instruction word.
- For loads and stores: runs a request/grant/response handshake with the data memory, formats store bytes/masks and sign/zero-extends load data.
- For all other instructions: forwards the ALU result to writeback.
- Exactly one instruction in flight.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned accesses raise exc and issue no bus request; 0 = accesses go out with mem_addr[1:0] forced to 0 and no exc.

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
in_valid  in  1  execute result valid
in_ready  out  1  stage can accept (combinational, =1 only in IDLE)
in_addr  in  32  ALU result (address or arithmetic result)
in_wdata  in  32  rs2 value for stores
in_inst  in  32  instruction word (opcode [6:0], rd [11:7], funct3 [14:12])
mem_req  out  1  bus request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address ({in_addr[31:2],2'b00})
mem_wmask  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data
wb_valid  out  1  writeback result valid
wb_ready  in  1  writeback accepts
wb_we  out  1  register write enable
wb_rd  out  5  destination register
wb_data  out  32  writeback value
exc  out  1  misaligned or illegal-funct3 access

Behaviour:
- Reset (resetn low): state IDLE; mem_req, mem_we, mem_wmask, wb_valid, wb_we, exc = 0; mem_addr, mem_wdata, wb_rd, wb_data = 0. Inputs are not captured while resetn is low.
- Reset mid-operation: the transaction is abandoned and mem_req drops immediately. A mem_rvalid arriving after reset is ignored.
- States: IDLE, REQ, RESP, OUT.
- IDLE, in_valid=1: capture inputs and decode opcode.
  - Load (0000011) or store (0100011), legal and aligned: go to REQ; mem_req=1 from the next cycle.
  - Any other opcode: go to OUT with wb_data=in_addr, wb_we=(rd!=0). Latency 1 cycle.
  - Exception (see below): go to OUT with exc=1, wb_we=0, wb_data=0. No bus request is made.
- REQ: mem_req, mem_we, mem_addr, mem_wmask and mem_wdata are held stable until mem_gnt.
  - On gnt, store: go to OUT, wb_we=0.
  - On gnt, load: go to RESP.
  - gnt and rvalid in the same cycle: load data is taken and the FSM goes directly to OUT.
- RESP: mem_req=0. Wait for mem_rvalid, then go to OUT with the formatted data and wb_we=(rd!=0). mem_rvalid is ignored in IDLE, REQ-without-gnt and OUT.
- OUT: wb_* held stable until wb_ready, then go to IDLE. No same-cycle accept, so throughput is at most 1 instruction per 2 cycles.
- Store formatting (off = addr[1:0]):
  - SB (000): wdata = byte replicated x4, wmask = 1<<off.
  - SH (001): wdata = half replicated x2, wmask = 0011 (off=0) or 1100 (off=2).
  - SW (010): wmask = 1111.
  - funct3 011 and above: illegal.
- Load formatting:
  - LB/LBU (000/100): byte lane off, sign-/zero-extended.
  - LH/LHU (001/101): half lane off[1], sign-/zero-extended.
  - LW (010): full word.
  - funct3 011, 110, 111: illegal.
- Exception conditions (exc=1):
  - Halfword access with off[0]=1 (ALIGN_CHECK=1).
  - Word access with off!=0 (ALIGN_CHECK=1).
  - Any illegal funct3.
- exc is valid only while wb_valid=1.

Test Plan:
- ADD (opcode 0110011, rd=5), in_addr=0x0000_002A, wb_ready=1 -> wb_valid one cycle after accept, wb_data=0x2A, wb_we=1, wb_rd=5, no mem_req.
- SB, in_addr=0x1003, in_wdata=0x0000_00A5, gnt 2 cycles after req -> mem_addr=0x1000, wmask=1000, wdata=0xA5A5A5A5, stable until gnt; then wb_valid, wb_we=0.
- LB rd=3 at 0x2002, rdata=0x0080_0000, rvalid 3 cycles after gnt -> wb_data=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080. Repeat with gnt+rvalid in the same cycle -> OUT on the next cycle.
- LW at 0x2001 (ALIGN_CHECK=1) -> no mem_req, wb_valid with exc=1, wb_we=0. Repeat with funct3=011 load -> same.
- LW rd=0 -> wb_we=0. Hold wb_ready=0 for 4 cycles -> wb_* stable, in_ready=0 throughout.
- Drop resetn while in RESP -> mem_req=0 and wb_valid=0 immediately. A late rvalid after reset is ignored; next LW completes normally.
